// File: rtl/retire_monitor.sv
// ---------------------------------------------------------------------------
// retire_monitor
//
// Run monitor for the pipelined CPU. It watches the WB-stage retirement
// stream, counts retired instructions and cycles spent running, and decides
// when a run is over. A run ends when the retired count hits a target, when
// a chosen end PC retires, or when retirement stalls for too long. The last
// TRACE_DEPTH retirements are kept in a ring buffer. Benches or a debug port
// can read them back, most recent first.
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   arm_i             one-cycle pulse: clear counters/trace and start a run
//   inst_target_i     retired count that ends the run (0 = disabled)
//   retire_valid_i    an instruction retires this cycle
//   retire_pc_i       PC of the retiring instruction
//   retire_rf_we_i    retiring instruction writes the register file
//   retire_rf_addr_i  destination register
//   retire_rf_data_i  writeback data
//   rd_idx_i          trace read index, 0 = most recent entry
//   running_o         monitor is in RUN
//   done_o            run ended on target count or end PC
//   timeout_o         run ended on a retirement stall
//   retired_count_o   instructions retired since arm
//   cycle_count_o     cycles spent in RUN since arm
//   rd_valid_o        registered: entry at rd_idx_i exists
//   rd_pc_o           registered trace PC
//   rd_rf_we_o        registered trace write-enable
//   rd_rf_addr_o      registered trace destination register
//   rd_rf_data_o      registered trace writeback data
// ---------------------------------------------------------------------------
module retire_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned STALL_LIMIT = 64,
    parameter logic [31:0] END_PC      = 32'hFFFF_FFFC
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           arm_i,
    input  logic [CNT_W-1:0]               inst_target_i,
    input  logic                           retire_valid_i,
    input  logic [31:0]                    retire_pc_i,
    input  logic                           retire_rf_we_i,
    input  logic [4:0]                     retire_rf_addr_i,
    input  logic [31:0]                    retire_rf_data_i,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx_i,
    output logic                           running_o,
    output logic                           done_o,
    output logic                           timeout_o,
    output logic [CNT_W-1:0]               retired_count_o,
    output logic [CNT_W-1:0]               cycle_count_o,
    output logic                           rd_valid_o,
    output logic [31:0]                    rd_pc_o,
    output logic                           rd_rf_we_o,
    output logic [4:0]                     rd_rf_addr_o,
    output logic [31:0]                    rd_rf_data_o
);

    localparam int unsigned IDX_W   = $clog2(TRACE_DEPTH);
    localparam int unsigned FILL_W  = $clog2(TRACE_DEPTH + 1);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               trace_we;

    logic [31:0]        trace_pc   [TRACE_DEPTH];
    logic               trace_we_r [TRACE_DEPTH];
    logic [4:0]         trace_addr [TRACE_DEPTH];
    logic [31:0]        trace_data [TRACE_DEPTH];

    logic [IDX_W-1:0]   rd_slot;
    logic               rd_hit;

    logic               rd_valid_q;
    logic [31:0]        rd_pc_q;
    logic               rd_rf_we_q;
    logic [4:0]         rd_rf_addr_q;
    logic [31:0]        rd_rf_data_q;

    // Next-state logic. Termination checks look at the post-update counters,
    // so a run that reaches its target on this retirement stops at this edge.
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        cycle_d   = cycle_q;
        stall_d   = stall_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        trace_we  = 1'b0;

        if (arm_i) begin
            // Arm restarts from any state; a same-cycle retirement is dropped.
            state_d   = S_RUN;
            retired_d = '0;
            cycle_d   = '0;
            stall_d   = '0;
            wr_ptr_d  = '0;
            fill_d    = '0;
        end else if (state_q == S_RUN) begin
            if (cycle_q != '1) begin
                cycle_d = cycle_q + 1'b1;
            end

            if (retire_valid_i) begin
                trace_we = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                stall_d  = '0;
                if (fill_q != FILL_W'(TRACE_DEPTH)) begin
                    fill_d = fill_q + 1'b1;
                end
                if (retired_q != '1) begin
                    retired_d = retired_q + 1'b1;
                end
            end else begin
                stall_d = stall_q + 1'b1;
            end

            if (retire_valid_i && (retire_pc_i == END_PC)) begin
                state_d = S_DONE;
            end else if ((inst_target_i != '0) && (retired_d == inst_target_i)) begin
                state_d = S_DONE;
            end else if (stall_d == STALL_W'(STALL_LIMIT)) begin
                state_d = S_TIMEOUT;
            end
        end
    end

    // State, counters and status flags. The flags are registered alongside
    // the state so nothing on retire_* reaches them combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
            cycle_q   <= '0;
            stall_q   <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            running_o <= 1'b0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            cycle_q   <= cycle_d;
            stall_q   <= stall_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            running_o <= (state_d == S_RUN);
            done_o    <= (state_d == S_DONE);
            timeout_o <= (state_d == S_TIMEOUT);
        end
    end

    // Trace storage needs no reset: the fill count alone decides which
    // slots may be reported.
    always_ff @(posedge clk_i) begin
        if (trace_we) begin
            trace_pc[wr_ptr_q]   <= retire_pc_i;
            trace_we_r[wr_ptr_q] <= retire_rf_we_i;
            trace_addr[wr_ptr_q] <= retire_rf_addr_i;
            trace_data[wr_ptr_q] <= retire_rf_data_i;
        end
    end

    // Index 0 is the slot just behind the write pointer. The pointer is a
    // power-of-two width, so the subtraction wraps modulo the depth.
    assign rd_slot = wr_ptr_q - IDX_W'(1) - rd_idx_i;
    assign rd_hit  = (FILL_W'(rd_idx_i) < fill_q);

    // Readback register. It samples the pre-write storage, so a read in a
    // retiring cycle still shows the previous most-recent entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q   <= 1'b0;
            rd_pc_q      <= '0;
            rd_rf_we_q   <= 1'b0;
            rd_rf_addr_q <= '0;
            rd_rf_data_q <= '0;
        end else begin
            rd_valid_q   <= rd_hit;
            rd_pc_q      <= rd_hit ? trace_pc[rd_slot]   : '0;
            rd_rf_we_q   <= rd_hit ? trace_we_r[rd_slot] : 1'b0;
            rd_rf_addr_q <= rd_hit ? trace_addr[rd_slot] : '0;
            rd_rf_data_q <= rd_hit ? trace_data[rd_slot] : '0;
        end
    end

    assign retired_count_o = retired_q;
    assign cycle_count_o   = cycle_q;
    assign rd_valid_o      = rd_valid_q;
    assign rd_pc_o         = rd_pc_q;
    assign rd_rf_we_o      = rd_rf_we_q;
    assign rd_rf_addr_o    = rd_rf_addr_q;
    assign rd_rf_data_o    = rd_rf_data_q;

endmodule

// File: doc/retire_monitor.md
Name: retire_monitor

Overview:
- Synthesisable run monitor for the pipelined CPU. It watches the WB-stage retirement stream and counts retired instructions and elapsed cycles.
- It declares a run finished on an instruction-count target, an end-PC match, or a retirement stall timeout.
- It keeps a ring-buffer trace of the last TRACE_DEPTH retirements (PC and register writeback) for readback by benches or a debug port.
- It replaces fixed cycle-count stop logic with a parametrised, self-terminating, depth-configurable monitor.

Parameters:
- CNT_W, 16, width of the retired-instruction and cycle counters.
- TRACE_DEPTH, 8, number of trace entries; power of two, minimum 2.
- STALL_LIMIT, 64, consecutive cycles without retirement in RUN that trigger a timeout; must be at least 1.
- END_PC, 32'hFFFF_FFFC, retire PC that ends the run; the default value is never fetched, which effectively disables it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse; clears counters and trace, then enters RUN.
- inst_target  in  CNT_W  retired count that ends the run; 0 disables this condition.
- retire_valid  in  1  WB-stage instruction retires this cycle.
- retire_pc  in  32  PC of the retiring instruction.
- retire_rf_we  in  1  retiring instruction writes the register file.
- retire_rf_addr  in  5  destination register.
- retire_rf_data  in  32  writeback data.
- rd_idx  in  log2(TRACE_DEPTH)  trace read index; 0 = most recent entry.
- running  out  1  state == RUN.
- done  out  1  state == DONE.
- timeout  out  1  state == TIMEOUT.
- retired_count  out  CNT_W  instructions retired since arm.
- cycle_count  out  CNT_W  cycles spent in RUN since arm.
- rd_valid  out  1  registered; the entry at rd_idx exists.
- rd_pc  out  32  registered trace PC.
- rd_rf_we  out  1  registered trace write-enable.
- rd_rf_addr  out  5  registered trace destination register.
- rd_rf_data  out  32  registered trace writeback data.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All counters, the write pointer, the entry count and every rd_* output are 0.
  - Trace storage contents are don't-care but are never reported valid.
- States: IDLE, RUN, DONE, TIMEOUT. Outputs are decoded from registered state, so there are no combinational paths from retire_* to the flags.
- On arm (any state):
  - Next state is RUN.
  - retired_count, cycle_count, stall counter, write pointer and entry count are cleared to 0.
  - A retire_valid in the same cycle as arm is ignored.
- In RUN, each cycle:
  - cycle_count increments, saturating at all-ones.
  - If retire_valid: write {pc, we, addr, data} at the write pointer. The pointer advances modulo TRACE_DEPTH, the entry count saturates at TRACE_DEPTH, retired_count increments (saturating), and the stall counter is cleared.
  - Otherwise the stall counter increments.
- Termination checks are evaluated on the post-update values. The first match wins, in this priority:
  1. RUN -> DONE when retire_valid and retire_pc == END_PC. The END_PC instruction is itself traced and counted.
  2. RUN -> DONE when inst_target != 0 and the new retired_count == inst_target.
  3. RUN -> TIMEOUT when the stall counter reaches STALL_LIMIT. A retirement in that same cycle clears the stall counter instead, so no timeout occurs.
- DONE and TIMEOUT are sticky. Counters and trace are frozen and retire_* is ignored until the next arm or reset.
- In IDLE nothing counts and retire_* is ignored.
- Trace readback has 1-cycle latency:
  - The physical slot is (wr_ptr − 1 − rd_idx) mod TRACE_DEPTH.
  - rd_valid = (rd_idx < entry count).
  - When rd_valid is 0, rd_pc, rd_rf_we, rd_rf_addr and rd_rf_data read 0.
- Read during write: rd_idx 0 sampled in a cycle with a retirement returns the previous most-recent entry. The new entry is visible the following cycle.
- inst_target is sampled every cycle. Changing it mid-run to a value below retired_count never triggers DONE; only an exact match does.
- Wrap-around: after more than TRACE_DEPTH retirements the oldest entries are overwritten, and rd_idx = TRACE_DEPTH−1 returns the oldest surviving entry.

Test Plan:
- Count stop: reset, arm, inst_target=45, one retirement every cycle with PC 0x3000, 0x3004, … -> done=1 the cycle after the 45th retirement; retired_count=45; cycle_count=45; rd_idx=0 returns pc 0x30B0.
- End PC: END_PC=0x3020, inst_target=0, retire PCs 0x3000..0x3020 with 2 idle cycles between retirements -> done after the 9th retirement; retired_count=9; rd_idx=0 gives pc 0x3020.
- Timeout: STALL_LIMIT=4, arm, 3 retirements then none -> timeout=1 exactly 4 cycles after the last retirement; retired_count=3. A retirement on the 4th idle cycle instead keeps running=1.
- Trace wrap: TRACE_DEPTH=8, 11 retirements with rf_we=1, addr=n, data=0x100+n for n=1..11 -> rd_idx 0..7 return addr 11..4 and data 0x10B..0x104; rd_valid=1 for all eight.
- Partial trace and re-arm: 3 retirements, then rd_idx=5 -> rd_valid=0 and rd_pc=0. Arm pulsed with a concurrent retire_valid -> running=1, retired_count=0, and rd_valid=0 for every index.
- Async reset mid-run: drop rst between clock edges during RUN -> running, done, timeout and counters are 0 immediately; after rst is released the block stays in IDLE until arm.
